// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencing controller.
// Op codes match the execute-stage 3-bit op field.
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MFHI  = 3'b110,
    OP_MFLO  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MUL_WAIT  = 2'd1,
    ST_DIV_ISSUE = 2'd2,
    ST_DIV_RUN   = 2'd3
  } state_e;

  localparam logic [1:0] SEL_DIV   = 2'b00;
  localparam logic [1:0] SEL_DIVU  = 2'b01;
  localparam logic [1:0] SEL_MULT  = 2'b10;
  localparam logic [1:0] SEL_MULTU = 2'b11;

  // MULT/MULTU/DIV/DIVU map onto unit_sel as {multiply, unsigned}.
  function automatic logic [1:0] op_to_sel(input logic [2:0] op);
    return {~op[1], op[0]};
  endfunction

endpackage

// File: rtl/md_hilo.sv
// Architectural HI/LO pair: full result write from the unit, or single-half move.
// One-cycle write latency; synchronous active-high reset clears both halves.
module md_hilo (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_res_we,
  input  logic [31:0] i_res_hi,
  input  logic [31:0] i_res_lo,
  input  logic        i_mv_we,
  input  logic        i_mv_hi,
  input  logic [31:0] i_mv_dat,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (i_res_we) begin
      r_hi <= i_res_hi;
      r_lo <= i_res_lo;
    end else if (i_mv_we) begin
      if (i_mv_hi) r_hi <= i_mv_dat;
      else         r_lo <= i_mv_dat;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: fixed-latency multiply, busy-handshake divide with watchdog, HI/LO commit.
// Stalls any request while busy; define MD_CTRL_DIV0_TRAP_EN to trap divide-by-zero instead of issuing it.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  output logic        o_stall,
  output logic [31:0] o_rd_val,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_unit_start,
  output logic [1:0]  o_unit_sel,
  output logic [31:0] o_unit_a,
  output logic [31:0] o_unit_b,
  input  logic        i_unit_busy,
  input  logic [31:0] i_unit_lo,
  input  logic [31:0] i_unit_hi,
  output logic        o_div0,
  output logic        o_timeout
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam int WD_W  = $clog2(DIV_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(DIV_TIMEOUT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WD_W-1:0]  r_wdog;
  logic [WD_W-1:0]  w_wdog_nxt;
  logic [31:0]      r_unit_a;
  logic [31:0]      r_unit_b;
  logic [1:0]       r_unit_sel;
  logic             r_unit_start;
  logic             w_start_nxt;
  logic             r_div0;
  logic             w_div0_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic             w_ld_ops;
  logic             w_res_we;
  logic             w_mv_we;
  logic [31:0]      w_hi;
  logic [31:0]      w_lo;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_wdog_nxt    = r_wdog;
    w_start_nxt   = r_unit_start;
    w_div0_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_ld_ops      = 1'b0;
    w_res_we      = 1'b0;
    w_mv_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          case (i_op)
            OP_MULT, OP_MULTU: begin
              w_ld_ops    = 1'b1;
              w_cnt_nxt   = CNT_LOAD;
              w_state_nxt = ST_MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
`ifdef MD_CTRL_DIV0_TRAP_EN
              if (i_rt_val == 32'd0) begin
                w_div0_nxt = 1'b1;
              end else begin
                w_ld_ops    = 1'b1;
                w_start_nxt = 1'b1;
                w_state_nxt = ST_DIV_ISSUE;
              end
`else
              w_ld_ops    = 1'b1;
              w_start_nxt = 1'b1;
              w_state_nxt = ST_DIV_ISSUE;
`endif
            end
            OP_MTHI, OP_MTLO: w_mv_we = 1'b1;
            default: ;
          endcase
        end
      end
      ST_MUL_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_res_we    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      // The divider may still report busy from a previous op here, so it is ignored.
      ST_DIV_ISSUE: begin
        w_wdog_nxt  = '0;
        w_state_nxt = ST_DIV_RUN;
      end
      ST_DIV_RUN: begin
        if (!i_unit_busy) begin
          w_res_we    = 1'b1;
          w_start_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (r_wdog == WD_LAST) begin
          w_timeout_nxt = 1'b1;
          w_start_nxt   = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_wdog_nxt = r_wdog + WD_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_wdog       <= '0;
      r_unit_a     <= 32'd0;
      r_unit_b     <= 32'd0;
      r_unit_sel   <= SEL_DIV;
      r_unit_start <= 1'b0;
      r_div0       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_wdog       <= w_wdog_nxt;
      r_unit_start <= w_start_nxt;
      r_div0       <= w_div0_nxt;
      r_timeout    <= w_timeout_nxt;
      if (w_ld_ops) begin
        r_unit_a   <= i_rs_val;
        r_unit_b   <= i_rt_val;
        r_unit_sel <= op_to_sel(i_op);
      end
    end
  end

  md_hilo u_hilo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_res_we (w_res_we),
    .i_res_hi (i_unit_hi),
    .i_res_lo (i_unit_lo),
    .i_mv_we  (w_mv_we),
    .i_mv_hi  (~i_op[0]),
    .i_mv_dat (i_rs_val),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  assign o_stall      = i_req & (r_state != ST_IDLE);
  assign o_rd_val     = (i_op == OP_MFHI) ? w_hi :
                        (i_op == OP_MFLO) ? w_lo : 32'd0;
  assign o_hi         = w_hi;
  assign o_lo         = w_lo;
  assign o_unit_start = r_unit_start;
  assign o_unit_sel   = r_unit_sel;
  assign o_unit_a     = r_unit_a;
  assign o_unit_b     = r_unit_b;
  assign o_div0       = r_div0;
  assign o_timeout    = r_timeout;

endmodule
